goldschmidt_div_seq: RTL and testbench

//  Sequential, parametrised signed integer divider using Goldschmidt iteration (F=2-D; N*=F; D*=F).

---
 rtl/goldschmidt_div_seq.sv | 144 ++++++++++++++
 tb/tb_goldschmidt_div_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/goldschmidt_div_seq.sv
// goldschmidt_div_seq: sequential signed Goldschmidt divider with exact correction; GSDIV_REMAINDER_EN adds rem port
module goldschmidt_div_seq #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 2*WIDTH,
  parameter int ITERS     = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             dbz,
  output logic             ovf
`ifdef GSDIV_REMAINDER_EN
  ,output logic [WIDTH-1:0] rem
`endif
);
  localparam int W  = WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int NW = FB + W + 1;
  localparam int DW = FB + 2;
  localparam int RW = 2*W + 4;
  localparam int CW = $clog2(ITERS) + 1;
  localparam int KW = $clog2(W + 2);
  localparam int SW = $clog2(FB + 1);
  localparam logic [DW-1:0] HALF = {2'b00, 1'b1, {(FB-1){1'b0}}};
  localparam logic [DW-1:0] TWO  = {2'b10, {FB{1'b0}}};
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAXV = ~MINV;
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_CORR, S_DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a, r_b, r_q;
  logic [NW-1:0] r_n;
  logic [DW-1:0] r_d, r_f;
  logic [W:0]    r_qm;
  logic [RW-1:0] r_r;
  logic          r_dbz, r_ovf;
  logic [W:0]    w_absa, w_absb, w_qc;
  logic [KW-1:0] w_k;
  logic [SW-1:0] w_sh;
  logic [NW-1:0] w_n0, w_nt;
  logic [DW-1:0] w_d0, w_dt;
  logic [W-1:0]  w_q;
  logic          w_sq, w_neg, w_ge, w_dbz, w_ovf;
  assign w_absa = r_a[W-1] ? -{r_a[W-1], r_a} : {1'b0, r_a};
  assign w_absb = r_b[W-1] ? -{r_b[W-1], r_b} : {1'b0, r_b};
  assign w_sq   = r_a[W-1] ^ r_b[W-1];
  assign w_dbz  = r_b == '0;
  assign w_ovf  = (r_a == MINV) && (r_b == '1);
  always_comb begin
    w_k = '0;
    for (int i = 0; i <= W; i++)
      if (w_absb[i]) w_k = KW'(i + 1);
  end
  // N keeps W+1 integer bits since it converges to the full-range quotient; b==0 normalises like |b|==1
  assign w_sh = SW'(FB) - ((w_k == '0) ? SW'(1) : SW'(w_k));
  assign w_n0 = NW'(w_absa) << w_sh;
  assign w_d0 = (w_absb == '0) ? HALF : DW'(w_absb) << w_sh;
  assign w_nt = NW'(({{DW{1'b0}}, r_n} * {{NW{1'b0}}, r_f}) >> FB);
  assign w_dt = DW'(({{DW{1'b0}}, r_d} * {{DW{1'b0}}, r_f}) >> FB);
  assign w_neg = r_r[RW-1];
  assign w_ge  = !w_neg && (r_r >= RW'(w_absb));
  assign w_qc  = w_neg ? r_qm - (W+1)'(1) : w_ge ? r_qm + (W+1)'(1) : r_qm;
  assign w_q   = w_dbz ? '0 : w_ovf ? MAXV : W'(w_sq ? -w_qc : w_qc);
`ifdef GSDIV_REMAINDER_EN
  logic [RW-1:0] w_rc;
  logic [W-1:0]  r_rem;
  assign w_rc = w_neg ? r_r + RW'(w_absb) : w_ge ? r_r - RW'(w_absb) : r_r;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_NORM : S_IDLE;
      S_NORM:  w_next = S_ITER;
      S_ITER:  w_next = (r_cnt == CW'(ITERS-1)) ? S_CORR : S_ITER;
      S_CORR:  w_next = (r_cnt != '0) ? S_DONE : S_CORR;
      default: w_next = out_ready ? S_IDLE : S_DONE;
    endcase
  end
  always_comb begin
    in_ready  = r_state == S_IDLE;
    out_valid = r_state == S_DONE;
    dbz       = out_valid & r_dbz;
    ovf       = out_valid & r_ovf;
    q         = r_q;
`ifdef GSDIV_REMAINDER_EN
    rem       = r_rem;
`endif
  end
  // CORR spans two cycles: raw quotient/remainder first, then the single-step fix and result write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_n   <= '0;
      r_d   <= '0;
      r_f   <= '0;
      r_qm  <= '0;
      r_r   <= '0;
      r_q   <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
`ifdef GSDIV_REMAINDER_EN
      r_rem <= '0;
`endif
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (r_state == S_IDLE && in_valid) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == S_NORM) begin
        r_n <= w_n0;
        r_d <= w_d0;
        r_f <= TWO - w_d0;
      end
      if (r_state == S_ITER) begin
        r_n <= w_nt;
        r_d <= w_dt;
        r_f <= TWO - w_dt;
      end
      if (r_state == S_CORR && r_cnt == '0) begin
        r_qm <= r_n[FB +: W+1];
        r_r  <= RW'(w_absa) - RW'(r_n[FB +: W+1]) * RW'(w_absb);
      end
      if (r_state == S_CORR && r_cnt != '0) begin
        r_q   <= w_q;
        r_dbz <= w_dbz;
        r_ovf <= w_ovf;
`ifdef GSDIV_REMAINDER_EN
        r_rem <= (w_dbz || w_ovf) ? '0 : W'(r_a[W-1] ? -w_rc : w_rc);
`endif
      end
    end
endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// tb_goldschmidt_div_seq: directed and random checks of goldschmidt_div_seq against integer-division reference
module tb_goldschmidt_div_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, dbz, ovf;
  logic signed [7:0] a = '0, b = '0, q;
  int total = 0, bad = 0;
`ifdef GSDIV_REMAINDER_EN
  logic signed [7:0] rem;
`endif
  goldschmidt_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .dbz(dbz), .ovf(ovf)
`ifdef GSDIV_REMAINDER_EN
    , .rem(rem)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run(input int ta, input int tb, input int stall);
    int n, eq, er;
    logic edbz, eovf;
    logic signed [7:0] q0;
    edbz = tb == 0;
    eovf = ta == -128 && tb == -1;
    eq = edbz ? 0 : eovf ? 127 : ta / tb;
    er = (edbz || eovf) ? 0 : ta % tb;
    a = 8'(ta);
    b = 8'(tb);
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 7);
    chk("q", q, eq);
    chk("dbz", 32'(dbz), 32'(edbz));
    chk("ovf", 32'(ovf), 32'(eovf));
    chk("in_ready_busy", 32'(in_ready), 0);
`ifdef GSDIV_REMAINDER_EN
    chk("rem", rem, er);
`else
    if (er > 1000) $display("unreachable %0d", er);
`endif
    q0 = q;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_q", q, q0);
      chk("stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_ready", 32'(in_ready), 1);
    chk("post_dbz", 32'(dbz), 0);
  endtask
  initial begin
    int ra, rb, s;
    #12;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_q", q, 0);
    chk("rst_dbz", 32'(dbz), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(100, 7, 0);
    run(-100, 7, 0);
    run(6, 3, 0);
    run(-1, 2, 0);
    run(-128, -1, 0);
    run(5, 0, 0);
    run(0, -5, 0);
    run(-128, 1, 0);
    run(127, -1, 0);
    run(-128, 127, 0);
    run(77, 128 - 256, 0);
    run(100, 7, 5);
    a = 8'sd100;
    b = 8'sd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_ghost_valid", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    run(50, -6, 0);
    for (int i = 0; i < 250; i++) begin
      ra = $signed(8'($urandom));
      rb = $signed(8'($urandom));
      s = $urandom_range(0, 7);
      if (s == 0) rb = 0;
      else if (s == 1) rb = ($urandom_range(0, 1) != 0) ? 1 : -1;
      else if (s == 2) ra = -128;
      run(ra, rb, $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
